// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM initiator: FSM state encodings,
// the default access length and the word-alignment helper.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_RECOVER = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  localparam int WAIT_CYCLES_DEF = 2;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter that times the oe/we strobe width; zero marks the
// last strobe cycle.
module sram_wait_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: load has priority, decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sram_ctrl.sv
// Single-word initiator for an asynchronous cs/oe/we SRAM: setup, a
// WAIT_CYCLES strobe window and one recovery cycle per access.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              cs,
  output logic              oe,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  if (WAIT_CYCLES < 1) begin : g_wait_chk
    $error("sram_ctrl: WAIT_CYCLES must be at least 1");
  end

  state_t state_r;
  logic   op_we_r;
  logic   cnt_load_s;
  logic   cnt_dec_s;
  logic   cnt_zero_s;

  assign cnt_load_s = (state_r == ST_SETUP);
  assign cnt_dec_s  = (state_r == ST_ACCESS) && !cnt_zero_s;

  sram_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load_s),
    .dec     (cnt_dec_s),
    .load_val(CNT_W'(WAIT_CYCLES - 1)),
    .zero    (cnt_zero_s)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      op_we_r   <= 1'b0;
      ready     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      cs        <= 1'b0;
      oe        <= 1'b0;
      we        <= 1'b0;
      addr      <= {ADDR_W{1'b0}};
      din       <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            op_we_r <= req_we;
            ready   <= 1'b0;
            if (is_word_aligned(req_addr[1:0])) begin
              // cs rises one cycle ahead of the strobe so oe/we never share a cs edge.
              addr    <= req_addr;
              din     <= req_wdata;
              cs      <= 1'b1;
              state_r <= ST_SETUP;
            end else begin
              state_r <= ST_ERR;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          oe      <= !op_we_r;
          we      <= op_we_r;
          state_r <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cnt_zero_s) begin
            oe        <= 1'b0;
            we        <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            if (!op_we_r) begin
              rsp_rdata <= dout;
            end else begin
              rsp_rdata <= rsp_rdata;
            end
            state_r <= ST_RECOVER;
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        ST_RECOVER: begin
          cs        <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          ready     <= 1'b1;
          state_r   <= ST_IDLE;
        end
        ST_ERR: begin
          // Error response shares the recovery cycle so its pulse timing matches.
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          state_r   <= ST_RECOVER;
        end
        default: begin
          cs        <= 1'b0;
          oe        <= 1'b0;
          we        <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          ready     <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: W=2 instance carries the main checks, W=1 and
// W=4 instances share the stimulus for the latency comparison.
module tb_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] dout;

  logic        ready_1, rsp_valid_1, rsp_err_1, cs_1, oe_1, we_1;
  logic [31:0] rsp_rdata_1, addr_1, din_1;
  logic        ready_2, rsp_valid_2, rsp_err_2, cs_2, oe_2, we_2;
  logic [31:0] rsp_rdata_2, addr_2, din_2;
  logic        ready_4, rsp_valid_4, rsp_err_4, cs_4, oe_4, we_4;
  logic [31:0] rsp_rdata_4, addr_4, din_4;

  int pass_cnt = 0;
  int total_cnt = 0;

  sram_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready_1), .rsp_valid(rsp_valid_1),
    .rsp_err(rsp_err_1), .rsp_rdata(rsp_rdata_1), .cs(cs_1), .oe(oe_1),
    .we(we_1), .addr(addr_1), .din(din_1), .dout(dout));

  sram_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready_2), .rsp_valid(rsp_valid_2),
    .rsp_err(rsp_err_2), .rsp_rdata(rsp_rdata_2), .cs(cs_2), .oe(oe_2),
    .we(we_2), .addr(addr_2), .din(din_2), .dout(dout));

  sram_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) dut_w4 (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready_4), .rsp_valid(rsp_valid_4),
    .rsp_err(rsp_err_4), .rsp_rdata(rsp_rdata_4), .cs(cs_4), .oe(oe_4),
    .we(we_4), .addr(addr_4), .din(din_4), .dout(dout));

  // SRAM model, addressed by the W=2 instance; unwritten words return A500000<idx>.
  logic [31:0] mem [0:15];
  logic [15:0] written;
  logic        mdl_clr;
  logic [3:0]  idx;

  assign idx  = addr_2[5:2];
  assign dout = written[idx] ? mem[idx] : {28'hA500000, idx};

  always @(posedge clk) begin
    if (mdl_clr) begin
      written <= 16'h0000;
    end else if (cs_2 && we_2) begin
      mem[idx]     <= din_2;
      written[idx] <= 1'b1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    req       = 1'b1;
    req_we    = wr;
    req_addr  = a;
    req_wdata = d;
    tick();
    req       = 1'b0;
  endtask

  int acc [3];
  int n_acc;
  int n_valid;
  int lat1, lat2, lat4;

  initial begin
    rst = 1'b1; req = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
    req_wdata = 32'h0; mdl_clr = 1'b1;

    // Reset held 3 cycles with a request pending.
    repeat (3) tick();
    chk("rst_ready", {31'b0, ready_2}, 32'd1);
    chk("rst_cs", {31'b0, cs_2}, 32'd0);
    chk("rst_oe_we", {30'b0, oe_2, we_2}, 32'd0);
    chk("rst_addr", addr_2, 32'h0);
    chk("rst_din", din_2, 32'h0);
    chk("rst_rsp", {30'b0, rsp_valid_2, rsp_err_2}, 32'd0);
    chk("rst_rdata", rsp_rdata_2, 32'h0);
    rst = 1'b0; req = 1'b0; mdl_clr = 1'b0;
    tick();
    chk("rst_no_strobe", {29'b0, cs_2, oe_2, we_2}, 32'd0);

    // Write 0x40 <- DEADBEEF.
    issue(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    chk("wr_e0_cs_we", {30'b0, cs_2, we_2}, 32'b10);
    chk("wr_e0_ready", {31'b0, ready_2}, 32'd0);
    chk("wr_din", din_2, 32'hDEAD_BEEF);
    chk("wr_addr", addr_2, 32'h0000_0040);
    tick();
    chk("wr_e1_cs_we", {30'b0, cs_2, we_2}, 32'b11);
    tick();
    chk("wr_e2_cs_we", {30'b0, cs_2, we_2}, 32'b11);
    tick();
    chk("wr_e3_cs_we", {30'b0, cs_2, we_2}, 32'b10);
    chk("wr_e3_rsp", {29'b0, rsp_valid_2, rsp_err_2, ready_2}, 32'b100);
    tick();
    chk("wr_e4_cs_rdy_vld", {29'b0, cs_2, ready_2, rsp_valid_2}, 32'b010);

    // Read 0x40 back.
    issue(1'b0, 32'h0000_0040, 32'h0);
    chk("rd_e0_oe", {30'b0, cs_2, oe_2}, 32'b10);
    tick();
    chk("rd_e1_oe", {30'b0, oe_2, we_2}, 32'b10);
    tick();
    chk("rd_e2_oe", {30'b0, oe_2, we_2}, 32'b10);
    tick();
    chk("rd_e3_oe", {31'b0, oe_2}, 32'd0);
    chk("rd_e3_vld", {30'b0, rsp_valid_2, rsp_err_2}, 32'b10);
    chk("rd_e3_rdata", rsp_rdata_2, 32'hDEAD_BEEF);
    tick();
    chk("rd_e4_ready", {31'b0, ready_2}, 32'd1);

    // Write 0x44 leaves rsp_rdata alone.
    issue(1'b1, 32'h0000_0044, 32'h1234_5678);
    repeat (4) tick();
    chk("wr2_rdata_kept", rsp_rdata_2, 32'hDEAD_BEEF);

    // Misaligned read.
    issue(1'b0, 32'h0000_0042, 32'h0);
    chk("mis_e0", {29'b0, cs_2, rsp_valid_2, ready_2}, 32'b000);
    tick();
    chk("mis_e1_cs", {31'b0, cs_2}, 32'd0);
    chk("mis_e1_rsp", {29'b0, rsp_valid_2, rsp_err_2, ready_2}, 32'b110);
    chk("mis_rdata", rsp_rdata_2, 32'hDEAD_BEEF);
    tick();
    chk("mis_e2", {29'b0, ready_2, rsp_valid_2, cs_2}, 32'b100);

    // Back-to-back reads of 0x44 with req held high.
    req = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0044;
    n_acc = 0; n_valid = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (req && ready_2 && n_acc < 3) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      tick();
      if (n_acc == 3) req = 1'b0;
      if (rsp_valid_2) n_valid++;
    end
    req = 1'b0;
    chk("b2b_accepts", n_acc, 32'd3);
    chk("b2b_gap0", acc[1] - acc[0], 32'd5);
    chk("b2b_gap1", acc[2] - acc[1], 32'd5);
    chk("b2b_rsp_count", n_valid, 32'd3);
    chk("b2b_rdata", rsp_rdata_2, 32'h1234_5678);

    // Reset during the second ACCESS cycle of a read.
    issue(1'b0, 32'h0000_0040, 32'h0);
    tick();
    tick();
    chk("rma_pre_oe", {31'b0, oe_2}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rma_strobes", {29'b0, cs_2, oe_2, we_2}, 32'd0);
    chk("rma_rsp", {30'b0, rsp_valid_2, rsp_err_2}, 32'd0);
    chk("rma_ready", {31'b0, ready_2}, 32'd1);
    tick();
    chk("rma_no_rsp", {31'b0, rsp_valid_2}, 32'd0);
    issue(1'b0, 32'h0000_0040, 32'h0);
    repeat (3) tick();
    chk("rma_next_vld", {31'b0, rsp_valid_2}, 32'd1);
    chk("rma_next_rdata", rsp_rdata_2, 32'hDEAD_BEEF);
    repeat (6) tick();

    // Read latency W+1 for W=1,2,4.
    chk("lat_all_ready", {29'b0, ready_1, ready_2, ready_4}, 32'b111);
    issue(1'b0, 32'h0000_0044, 32'h0);
    lat1 = -1; lat2 = -1; lat4 = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rsp_valid_1 && lat1 < 0) lat1 = k;
      if (rsp_valid_2 && lat2 < 0) lat2 = k;
      if (rsp_valid_4 && lat4 < 0) lat4 = k;
    end
    chk("lat_w1", lat1, 32'd2);
    chk("lat_w2", lat2, 32'd3);
    chk("lat_w4", lat4, 32'd5);
    chk("lat_w1_rdata", rsp_rdata_1, 32'h1234_5678);
    chk("lat_w4_rdata", rsp_rdata_4, 32'h1234_5678);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
